// File: rtl/mem_access_arbiter_pkg.sv
// mem_access_arbiter_pkg
// Shared codes for the memory access arbiter and its grant logic:
//   - memory command codes driven on mem_i_signal / mem_d_signal
//   - memory status codes returned on mem_status
//   - access width codes used on d_req_type / mem_data_type
//   - arbiter FSM state encoding
package mem_access_arbiter_pkg;

   localparam logic [1:0] MEM_NOP   = 2'd0;
   localparam logic [1:0] MEM_READ  = 2'd1;
   localparam logic [1:0] MEM_WRITE = 2'd2;

   localparam logic [1:0] MEM_RESTING       = 2'd0;
   localparam logic [1:0] MEM_INST_FINISHED = 2'd1;
   localparam logic [1:0] MEM_DATA_FINISHED = 2'd2;

   localparam logic [2:0] ONE_BYTE   = 3'd0;
   localparam logic [2:0] TWO_BYTE   = 3'd1;
   localparam logic [2:0] FOUR_BYTE  = 3'd2;
   localparam logic [2:0] EIGHT_BYTE = 3'd3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_e;

   // Command to place on the data-side memory port for one beat.
   function automatic logic [1:0] d_command(input logic is_write);
      return is_write ? MEM_WRITE : MEM_READ;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_grant.sv
// mem_arb_grant
// Fixed-priority grant (data side first) with a starvation counter that
// forces the instruction side to win after STARVE_LIMIT consecutive losses.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   arb_en       high in cycles where the arbiter may start a new burst
//   i_valid      instruction-side request
//   d_valid      data-side request
//   grant_i      instruction side wins this cycle
//   grant_d      data side wins this cycle
module mem_arb_grant #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic i_valid,
   input  logic d_valid,
   output logic grant_i,
   output logic grant_d
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             starved;

   assign starved = (starve_cnt_q == LIMIT);

   // The data side wins ties unless the instruction side has lost too often.
   always_comb begin
      grant_i = arb_en & i_valid & (~d_valid | starved);
      grant_d = arb_en & d_valid & ~grant_i;
   end

   // Count only real losses (i was asking, d was granted); saturate at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_i) begin
         starve_cnt_d = '0;
      end else if (grant_d && i_valid && !starved) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Sole master of the main memory port. Grants one cache at a time and walks
// the granted burst as 4-byte beats: ISSUE drives one command, WAIT holds
// until memory reports the beat finished (or a timeout aborts), DONE reports
// completion.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   i_req_* / i_rdata* / i_done    instruction-cache read interface
//   d_req_* / d_wdata / d_beat_idx data-cache read/write interface
//   d_rdata* / d_done              data-cache read return and completion
//   err                            pulses with *_done when a burst timed out
//   mem_*                          main memory command/address/data/status
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH       = 20,
   parameter int DATA_LEN         = 32,
   parameter int ENTRY_INDEX_SIZE = 3,
   parameter int STARVE_LIMIT     = 4,
   parameter int TIMEOUT          = 15
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_req_valid,
   input  logic [ADDR_WIDTH-1:0]       i_req_addr,
   input  logic [ENTRY_INDEX_SIZE:0]   i_req_len,
   output logic                        i_req_ack,
   output logic [DATA_LEN-1:0]         i_rdata,
   output logic                        i_rdata_valid,
   output logic                        i_done,
   input  logic                        d_req_valid,
   input  logic                        d_req_write,
   input  logic [ADDR_WIDTH-1:0]       d_req_addr,
   input  logic [ENTRY_INDEX_SIZE:0]   d_req_len,
   input  logic [2:0]                  d_req_type,
   input  logic [DATA_LEN-1:0]         d_wdata,
   output logic [ENTRY_INDEX_SIZE:0]   d_beat_idx,
   output logic                        d_req_ack,
   output logic [DATA_LEN-1:0]         d_rdata,
   output logic                        d_rdata_valid,
   output logic                        d_done,
   output logic                        err,
   output logic [1:0]                  mem_i_signal,
   output logic [1:0]                  mem_d_signal,
   output logic [ADDR_WIDTH-1:0]       mem_i_addr,
   output logic [ADDR_WIDTH-1:0]       mem_d_addr,
   output logic [DATA_LEN-1:0]         mem_wdata,
   output logic [2:0]                  mem_data_type,
   input  logic [DATA_LEN-1:0]         mem_data,
   input  logic [1:0]                  mem_status
);

   localparam int LEN_W  = ENTRY_INDEX_SIZE + 1;
   localparam int TOUT_W = $clog2(TIMEOUT + 1);

   arb_state_e state_q, state_d;

   logic                  side_q, side_d;
   logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  write_q, write_d;
   logic [LEN_W-1:0]      beat_idx_q, beat_idx_d;
   logic [TOUT_W-1:0]     tout_q, tout_d;
   logic                  abort_q, abort_d;
   logic                  i_ack_q, i_ack_d, d_ack_q, d_ack_d;
   logic [DATA_LEN-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic                  i_done_q, i_done_d, d_done_q, d_done_d;
   logic                  err_q, err_d;
   logic [1:0]            mem_i_sig_q, mem_i_sig_d, mem_d_sig_q, mem_d_sig_d;
   logic [2:0]            data_type_q, data_type_d;

   logic                  arb_en, grant_i, grant_d, granted;
   logic [LEN_W-1:0]      req_len;
   logic                  beat_finished, last_beat, timed_out;

   // A done pulse is still visible to the requester in the IDLE cycle right
   // after DONE, so its valid is not taken as a new request until one cycle later.
   assign arb_en  = (state_q == ARB_IDLE) && !i_done_q && !d_done_q;
   assign granted = grant_i | grant_d;
   assign req_len = grant_d ? d_req_len : i_req_len;

   assign beat_finished = (state_q == ARB_WAIT) &&
                          (mem_status == (side_q ? MEM_DATA_FINISHED : MEM_INST_FINISHED));
   assign last_beat     = (beat_idx_q + LEN_W'(1)) == len_q;
   assign timed_out     = (state_q == ARB_WAIT) && !beat_finished &&
                          (tout_q == TOUT_W'(TIMEOUT - 1));

   mem_arb_grant #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (arb_en),
      .i_valid (i_req_valid),
      .d_valid (d_req_valid),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Burst sequencing: zero-length grants skip straight to DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE:  if (granted) state_d = (req_len == '0) ? ARB_DONE : ARB_ISSUE;
         ARB_ISSUE: state_d = ARB_WAIT;
         ARB_WAIT: begin
            if (beat_finished) state_d = last_beat ? ARB_DONE : ARB_ISSUE;
            else if (timed_out) state_d = ARB_DONE;
         end
         ARB_DONE:  state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   // Memory commands are registered on the transition into ISSUE so they are
   // on the port exactly during the ISSUE cycle. The beat address is kept as a
   // running sum (base + 4*beat_idx) and wraps naturally at ADDR_WIDTH bits.
   always_comb begin
      side_d      = side_q;
      beat_addr_d = beat_addr_q;
      len_d       = len_q;
      write_d     = write_q;
      beat_idx_d  = beat_idx_q;
      tout_d      = tout_q;
      abort_d     = abort_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      data_type_d = data_type_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      err_d       = 1'b0;
      mem_i_sig_d = MEM_NOP;
      mem_d_sig_d = MEM_NOP;
      unique case (state_q)
         ARB_IDLE: begin
            if (granted) begin
               side_d      = grant_d;
               beat_addr_d = grant_d ? d_req_addr : i_req_addr;
               len_d       = req_len;
               write_d     = grant_d & d_req_write;
               beat_idx_d  = '0;
               abort_d     = 1'b0;
               i_ack_d     = grant_i;
               d_ack_d     = grant_d;
               data_type_d = (req_len == LEN_W'(1)) ? d_req_type : FOUR_BYTE;
               if (req_len != '0) begin
                  if (grant_d) mem_d_sig_d = d_command(d_req_write);
                  else         mem_i_sig_d = MEM_READ;
               end
            end
         end
         ARB_ISSUE: begin
            tout_d = '0;
         end
         ARB_WAIT: begin
            if (beat_finished) begin
               beat_idx_d = beat_idx_q + LEN_W'(1);
               if (!write_q) begin
                  if (side_q) begin
                     d_rdata_d  = mem_data;
                     d_rvalid_d = 1'b1;
                  end else begin
                     i_rdata_d  = mem_data;
                     i_rvalid_d = 1'b1;
                  end
               end
               if (!last_beat) begin
                  beat_addr_d = beat_addr_q + ADDR_WIDTH'(4);
                  data_type_d = FOUR_BYTE;
                  if (side_q) mem_d_sig_d = d_command(write_q);
                  else        mem_i_sig_d = MEM_READ;
               end
            end else if (timed_out) begin
               abort_d = 1'b1;
            end else begin
               tout_d = tout_q + TOUT_W'(1);
            end
         end
         ARB_DONE: begin
            i_done_d   = ~side_q;
            d_done_d   = side_q;
            err_d      = abort_q;
            beat_idx_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         side_q      <= 1'b0;
         beat_addr_q <= '0;
         len_q       <= '0;
         write_q     <= 1'b0;
         beat_idx_q  <= '0;
         tout_q      <= '0;
         abort_q     <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
         mem_i_sig_q <= MEM_NOP;
         mem_d_sig_q <= MEM_NOP;
         data_type_q <= FOUR_BYTE;
      end else begin
         side_q      <= side_d;
         beat_addr_q <= beat_addr_d;
         len_q       <= len_d;
         write_q     <= write_d;
         beat_idx_q  <= beat_idx_d;
         tout_q      <= tout_d;
         abort_q     <= abort_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_rvalid_q  <= i_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
         mem_i_sig_q <= mem_i_sig_d;
         mem_d_sig_q <= mem_d_sig_d;
         data_type_q <= data_type_d;
      end
   end

   // The d-cache supplies write data combinationally from d_beat_idx, so the
   // write beat is forwarded straight through while the command is on the port.
   assign mem_wdata     = d_wdata;
   assign mem_i_signal  = mem_i_sig_q;
   assign mem_d_signal  = mem_d_sig_q;
   assign mem_i_addr    = beat_addr_q;
   assign mem_d_addr    = beat_addr_q;
   assign mem_data_type = data_type_q;
   assign d_beat_idx    = beat_idx_q;
   assign i_req_ack     = i_ack_q;
   assign d_req_ack     = d_ack_q;
   assign i_rdata       = i_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign i_rdata_valid = i_rvalid_q;
   assign d_rdata_valid = d_rvalid_q;
   assign i_done        = i_done_q;
   assign d_done        = d_done_q;
   assign err           = err_q;

endmodule
